// File: rtl/comp_stim_checker.sv
// Self-test engine for a comparator: sweeps every {a,b} operand pair, waits a
// programmable settle time, checks {g,l,e} against an unsigned golden compare,
// counts mismatches and captures the first failing vector and observation.
module comp_stim_checker #(
   parameter int unsigned WIDTH  = 1,
   parameter int unsigned SETTLE = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   output logic [WIDTH-1:0]     a_out,
   output logic [WIDTH-1:0]     b_out,
   input  logic                 g_in,
   input  logic                 l_in,
   input  logic                 e_in,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [2*WIDTH:0]     err_count,
   output logic [2*WIDTH-1:0]   fail_vec,
   output logic [2:0]           fail_obs
);

   localparam int unsigned VW    = 2 * WIDTH;
   localparam int unsigned EW    = VW + 1;
   localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_DRIVE = 3'd1,
      S_WAIT  = 3'd2,
      S_CHECK = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [VW-1:0]      r_vec;
   logic [CNT_W-1:0]   r_cnt;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic               r_busy;
   logic               r_done;
   logic               r_pass;
   logic [EW-1:0]      r_err;
   logic [VW-1:0]      r_fail_vec;
   logic [2:0]         r_fail_obs;

   logic [2:0]         w_exp;
   logic [2:0]         w_obs;
   logic               w_mismatch;
   logic               w_last;

   // Golden unsigned compare on the operands currently driven to the comparator
   always_comb begin
      w_exp      = {(r_a > r_b), (r_a < r_b), (r_a == r_b)};
      w_obs      = {g_in, l_in, e_in};
      w_mismatch = (w_obs != w_exp);
      w_last     = (r_vec == {VW{1'b1}});
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state logic; start is only honoured when not sweeping
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE,
         S_DONE:  if (start) w_state_nxt = S_DRIVE;
         S_DRIVE: w_state_nxt = S_WAIT;
         S_WAIT:  if (r_cnt == '0) w_state_nxt = S_CHECK;
         S_CHECK: w_state_nxt = w_last ? S_DONE : S_DRIVE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Sweep datapath, result capture and registered status flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vec      <= '0;
         r_cnt      <= '0;
         r_a        <= '0;
         r_b        <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_pass     <= 1'b0;
         r_err      <= '0;
         r_fail_vec <= '0;
         r_fail_obs <= '0;
      end else begin
         r_busy <= (w_state_nxt == S_DRIVE) || (w_state_nxt == S_WAIT) ||
                   (w_state_nxt == S_CHECK);
         r_done <= (w_state_nxt == S_DONE);
         case (r_state)
            S_IDLE,
            S_DONE: begin
               if (start) begin
                  r_vec      <= '0;
                  r_err      <= '0;
                  r_fail_vec <= '0;
                  r_fail_obs <= '0;
                  r_pass     <= 1'b0;
               end
            end
            S_DRIVE: begin
               r_a   <= r_vec[VW-1:WIDTH];
               r_b   <= r_vec[WIDTH-1:0];
               r_cnt <= CNT_W'(SETTLE - 1);
            end
            S_WAIT: begin
               if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
            end
            S_CHECK: begin
               if (w_mismatch) begin
                  r_err <= r_err + EW'(1);
                  if (r_err == '0) begin
                     r_fail_vec <= r_vec;
                     r_fail_obs <= w_obs;
                  end
               end
               if (w_last) r_pass <= (r_err == '0) && !w_mismatch;
               else        r_vec  <= r_vec + VW'(1);
            end
            default: ;
         endcase
      end
   end

   assign a_out     = r_a;
   assign b_out     = r_b;
   assign busy      = r_busy;
   assign done      = r_done;
   assign pass      = r_pass;
   assign err_count = r_err;
   assign fail_vec  = r_fail_vec;
   assign fail_obs  = r_fail_obs;

endmodule

// File: tb/tb_comp_stim_checker.sv
// Directed bench: two checker instances (WIDTH=1/SETTLE=1 and WIDTH=2/SETTLE=3)
// each facing a behavioural comparator that can be golden or deliberately broken.
module tb_comp_stim_checker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   int   n_cmp = 0;
   int   n_err = 0;

   // Instance 1: WIDTH=1, SETTLE=1
   logic       start1;
   logic [0:0] a1, b1;
   logic       g1, l1, e1;
   logic       busy1, done1, pass1;
   logic [2:0] err1;
   logic [1:0] fv1;
   logic [2:0] fo1;
   int         mode1;
   logic [1:0] seq1 [4];

   // Instance 2: WIDTH=2, SETTLE=3
   logic       start2;
   logic [1:0] a2, b2;
   logic       g2, l2, e2;
   logic       busy2, done2, pass2;
   logic [4:0] err2;
   logic [3:0] fv2;
   logic [2:0] fo2;
   int         mode2;

   // mode: 0 golden, 1 g stuck 0, 2 g/l swapped, 3 e stuck 1
   always_comb begin
      g1 = (a1 > b1); l1 = (a1 < b1); e1 = (a1 == b1);
      if (mode1 == 1)      g1 = 1'b0;
      else if (mode1 == 2) begin g1 = (a1 < b1); l1 = (a1 > b1); end
      else if (mode1 == 3) e1 = 1'b1;
   end

   always_comb begin
      g2 = (a2 > b2); l2 = (a2 < b2); e2 = (a2 == b2);
      if (mode2 == 1)      g2 = 1'b0;
      else if (mode2 == 2) begin g2 = (a2 < b2); l2 = (a2 > b2); end
      else if (mode2 == 3) e2 = 1'b1;
   end

   comp_stim_checker #(.WIDTH(1), .SETTLE(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1),
      .a_out(a1), .b_out(b1), .g_in(g1), .l_in(l1), .e_in(e1),
      .busy(busy1), .done(done1), .pass(pass1),
      .err_count(err1), .fail_vec(fv1), .fail_obs(fo1)
   );

   comp_stim_checker #(.WIDTH(2), .SETTLE(3)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2),
      .a_out(a2), .b_out(b2), .g_in(g2), .l_in(l2), .e_in(e2),
      .busy(busy2), .done(done2), .pass(pass2),
      .err_count(err2), .fail_vec(fv2), .fail_obs(fo2)
   );

   // Pulse start1 and count busy cycles; record a/b shown in each vector's WAIT
   task automatic sweep1(output int cyc);
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      cyc = 0;
      for (int i = 0; i < 200; i++) begin
         if (!busy1) break;
         for (int v = 0; v < 4; v++) if (i == 3 * v + 1) seq1[v] = {a1, b1};
         cyc++;
         @(negedge clk);
      end
   endtask

   // Count busy cycles of instance 2 from the current negedge, optional start pulse
   task automatic wait2(input int pulse_at, output int cyc);
      cyc = 0;
      for (int i = 0; i < 400; i++) begin
         if (!busy2) break;
         start2 = (i == pulse_at);
         cyc++;
         @(negedge clk);
      end
      start2 = 1'b0;
   endtask

   task automatic sweep2(input int pulse_at, output int cyc);
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      wait2(pulse_at, cyc);
   endtask

   task automatic test_reset();
      n_cmp++; if ({a1, b1, busy1, done1, pass1} !== 5'b0) begin n_err++; $display("FAIL rst_flags1 got=%b want=00000", {a1, b1, busy1, done1, pass1}); end
      n_cmp++; if ({err1, fv1, fo1} !== 8'b0) begin n_err++; $display("FAIL rst_result1 got=%h want=00", {err1, fv1, fo1}); end
      n_cmp++; if ({a2, b2, busy2, done2, pass2} !== 7'b0) begin n_err++; $display("FAIL rst_flags2 got=%b want=0000000", {a2, b2, busy2, done2, pass2}); end
      n_cmp++; if ({err2, fv2, fo2} !== 12'b0) begin n_err++; $display("FAIL rst_result2 got=%h want=000", {err2, fv2, fo2}); end
   endtask

   task automatic test_golden1();
      int cyc;
      mode1 = 0;
      sweep1(cyc);
      n_cmp++; if (cyc !== 12) begin n_err++; $display("FAIL golden1_busy_cycles got=%0d want=12", cyc); end
      n_cmp++; if ({done1, pass1, busy1} !== 3'b110) begin n_err++; $display("FAIL golden1_done_pass got=%b want=110", {done1, pass1, busy1}); end
      n_cmp++; if (err1 !== 3'd0) begin n_err++; $display("FAIL golden1_err got=%0d want=0", err1); end
      for (int v = 0; v < 4; v++) begin
         n_cmp++; if (seq1[v] !== 2'(v)) begin n_err++; $display("FAIL golden1_ab_seq[%0d] got=%b want=%b", v, seq1[v], 2'(v)); end
      end
   endtask

   task automatic test_g_stuck();
      int cyc;
      mode1 = 1;
      sweep1(cyc);
      n_cmp++; if (err1 !== 3'd1) begin n_err++; $display("FAIL gstuck_err got=%0d want=1", err1); end
      n_cmp++; if (fv1 !== 2'b10) begin n_err++; $display("FAIL gstuck_fail_vec got=%b want=10", fv1); end
      n_cmp++; if (fo1 !== 3'b000) begin n_err++; $display("FAIL gstuck_fail_obs got=%b want=000", fo1); end
      n_cmp++; if ({done1, pass1} !== 2'b10) begin n_err++; $display("FAIL gstuck_done_pass got=%b want=10", {done1, pass1}); end
   endtask

   task automatic test_swap();
      int cyc;
      mode1 = 2;
      sweep1(cyc);
      n_cmp++; if (err1 !== 3'd2) begin n_err++; $display("FAIL swap_err got=%0d want=2", err1); end
      n_cmp++; if (fv1 !== 2'b01) begin n_err++; $display("FAIL swap_fail_vec got=%b want=01", fv1); end
      n_cmp++; if (fo1 !== 3'b100) begin n_err++; $display("FAIL swap_fail_obs got=%b want=100", fo1); end
      n_cmp++; if (pass1 !== 1'b0) begin n_err++; $display("FAIL swap_pass got=%b want=0", pass1); end
      mode1 = 0;
   endtask

   task automatic test_golden2();
      int cyc;
      mode2 = 0;
      sweep2(-1, cyc);
      n_cmp++; if (cyc !== 80) begin n_err++; $display("FAIL golden2_busy_cycles got=%0d want=80", cyc); end
      n_cmp++; if ({done2, pass2, err2} !== 7'b1100000) begin n_err++; $display("FAIL golden2_result got=%b want=1100000", {done2, pass2, err2}); end
   endtask

   task automatic test_restart();
      int cyc;
      n_cmp++; if ({a2, b2} !== 4'hF) begin n_err++; $display("FAIL restart_hold_ab got=%h want=f", {a2, b2}); end
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      n_cmp++; if ({done2, pass2, busy2} !== 3'b001) begin n_err++; $display("FAIL restart_edge got=%b want=001", {done2, pass2, busy2}); end
      wait2(-1, cyc);
      n_cmp++; if (cyc !== 80) begin n_err++; $display("FAIL restart_busy_cycles got=%0d want=80", cyc); end
      n_cmp++; if ({done2, pass2, err2} !== 7'b1100000) begin n_err++; $display("FAIL restart_result got=%b want=1100000", {done2, pass2, err2}); end
   endtask

   task automatic test_start_mid();
      int cyc;
      mode2 = 0;
      sweep2(20, cyc);
      n_cmp++; if (cyc !== 80) begin n_err++; $display("FAIL startmid_busy_cycles got=%0d want=80", cyc); end
      n_cmp++; if ({done2, pass2, err2} !== 7'b1100000) begin n_err++; $display("FAIL startmid_result got=%b want=1100000", {done2, pass2, err2}); end
   endtask

   task automatic test_e_stuck();
      int cyc;
      mode2 = 3;
      sweep2(-1, cyc);
      n_cmp++; if (err2 !== 5'd12) begin n_err++; $display("FAIL estuck_err got=%0d want=12", err2); end
      n_cmp++; if (fv2 !== 4'b0001) begin n_err++; $display("FAIL estuck_fail_vec got=%b want=0001", fv2); end
      n_cmp++; if (fo2 !== 3'b011) begin n_err++; $display("FAIL estuck_fail_obs got=%b want=011", fo2); end
      n_cmp++; if (pass2 !== 1'b0) begin n_err++; $display("FAIL estuck_pass got=%b want=0", pass2); end
   endtask

   task automatic test_reset_mid();
      int cyc;
      mode2 = 3;
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      repeat (30) @(negedge clk);
      n_cmp++; if (busy2 !== 1'b1) begin n_err++; $display("FAIL rstmid_busy_before got=%b want=1", busy2); end
      n_cmp++; if (err2 === 5'd0) begin n_err++; $display("FAIL rstmid_err_before got=%0d want=nonzero", err2); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if ({a2, b2, busy2, done2, pass2} !== 7'b0) begin n_err++; $display("FAIL rstmid_flags got=%b want=0000000", {a2, b2, busy2, done2, pass2}); end
      n_cmp++; if ({err2, fv2, fo2} !== 12'b0) begin n_err++; $display("FAIL rstmid_result got=%h want=000", {err2, fv2, fo2}); end
      @(negedge clk);
      rst_n = 1'b1;
      mode2 = 0;
      @(negedge clk);
      sweep2(-1, cyc);
      n_cmp++; if (cyc !== 80) begin n_err++; $display("FAIL rstmid_rerun_cycles got=%0d want=80", cyc); end
      n_cmp++; if ({done2, pass2, err2} !== 7'b1100000) begin n_err++; $display("FAIL rstmid_rerun_result got=%b want=1100000", {done2, pass2, err2}); end
   endtask

   initial begin
      rst_n  = 1'b0;
      start1 = 1'b0;
      start2 = 1'b0;
      mode1  = 0;
      mode2  = 0;
      repeat (2) @(negedge clk);
      test_reset();
      rst_n = 1'b1;
      @(negedge clk);
      test_golden1();
      test_g_stuck();
      test_swap();
      test_golden2();
      test_restart();
      test_start_mid();
      test_e_stuck();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
